store_narrow_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 30 +++
 rtl/store_lane_gen.sv | 38 +++
 rtl/store_narrow_unit.sv | 121 ++++++++++++
 tb/tb_store_narrow_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the store narrowing path: access sizes,
// store FSM states and the read-modify-write lane merge helper.
package mips_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      READ   = 2'b01,
      WRITE  = 2'b10,
      FINISH = 2'b11
   } store_state_e;

   // Lanes with be=1 take new data, the rest keep the old word.
   function automatic logic [31:0] merge_lanes(
      input logic [31:0] new_d,
      input logic [31:0] old_d,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*8 +: 8] = be[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane steering for stores: replicates data into lanes,
// builds byte enables and flags misaligned/reserved-size requests.
// Ports: addr_lo, size, data in; wdata, be, misalign out.
module store_lane_gen
   import mips_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misalign
);

   always_comb begin
      wdata    = data;
      be       = 4'b1111;
      misalign = 1'b0;
      unique case (size)
         SIZE_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            wdata    = {2{data[15:0]}};
            be       = 4'b0011 << addr_lo;
            misalign = addr_lo[0];
         end
         SIZE_WORD: begin
            misalign = |addr_lo;
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts one store at a time, drives a single
// word-aligned memory write (or read-then-write when STORE_RMW_EN is
// defined), then pulses done; misaligned requests pulse misalign.
// Ports: clk, rst_n; req_valid/req_ready/req_addr/req_size/req_data;
// done, misalign; mem_addr/mem_wdata/mem_be/mem_we/mem_re/mem_rdata/mem_ack.
module store_narrow_unit
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_data,
   output logic        done,
   output logic        misalign,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   store_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic [3:0]   be_q, be_d;
   logic         mis_q, mis_d;

   logic [31:0]  lg_wdata;
   logic [3:0]   lg_be;
   logic         lg_mis;

   store_lane_gen u_lane_gen (
      .addr_lo  (req_addr[1:0]),
      .size     (req_size),
      .data     (req_data),
      .wdata    (lg_wdata),
      .be       (lg_be),
      .misalign (lg_mis)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      mis_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (lg_mis) begin
                  mis_d = 1'b1;
               end else begin
                  addr_d  = {req_addr[31:2], 2'b00};
                  wdata_d = lg_wdata;
                  be_d    = lg_be;
`ifdef STORE_RMW_EN
                  state_d = (req_size == SIZE_WORD) ? WRITE : READ;
`else
                  state_d = WRITE;
`endif
               end
            end
         end
         READ: begin
`ifdef STORE_RMW_EN
            if (mem_ack) begin
               wdata_d = merge_lanes(wdata_q, mem_rdata, be_q);
               be_d    = 4'b1111;
               state_d = WRITE;
            end
`else
            state_d = IDLE;
`endif
         end
         WRITE: begin
            if (mem_ack) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         mis_q   <= mis_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign done      = (state_q == FINISH);
   assign misalign  = mis_q;
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

`ifdef STORE_RMW_EN
   assign mem_re = (state_q == READ);
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;
   assign mem_re       = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: directed stores push expected
// writes/done/misalign events; a negedge monitor pops and compares.
module tb_store_narrow_unit;
   import mips_pkg::*;

   localparam int K_WR   = 0;
   localparam int K_DONE = 1;
   localparam int K_MIS  = 2;
   localparam logic [31:0] RDATA = 32'h1122_3344;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_data = '0;
   logic        done, misalign;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we, mem_re;
   logic [31:0] mem_rdata = RDATA;
   logic        mem_ack = 1'b0;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;

   store_narrow_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_data  (req_data),
      .done      (done),
      .misalign  (misalign),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] n,
                                       input logic [31:0] o,
                                       input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
      return r;
   endfunction

   task automatic pop_cmp(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_event: got kind %0d want none", kind);
      end else begin
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         if (kind == K_WR) begin
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
            chk("wr_be", {28'd0, mem_be}, {28'd0, e.be});
         end else begin
            chk(kind == K_DONE ? "done_cycle" : "mis_cycle", cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we || mem_re) chk("we_re_excl", mem_we & mem_re, 0);
         if (mem_we && mem_ack) pop_cmp(K_WR);
         if (done) pop_cmp(K_DONE);
         if (misalign) pop_cmp(K_MIS);
      end
   end

   task automatic store(input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] ew, input logic [3:0] ebe,
                        input logic mis);
      int c;
      int extra;
      logic [31:0] xw;
      logic [3:0]  xbe;
      exp_t e;
      extra = 0;
      xw    = ew;
      xbe   = ebe;
`ifdef STORE_RMW_EN
      if (!mis && sz != SIZE_WORD) begin
         extra = 1;
         xw    = mrg(ew, RDATA, ebe);
         xbe   = 4'b1111;
      end
`endif
      chk("ready_idle", req_ready, 1);
      c = cyc;
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = sz;
      req_data  = d;
      if (mis) begin
         e = '{K_MIS, 0, 0, 0, c + 1};
         q.push_back(e);
      end else begin
         e = '{K_WR, {a[31:2], 2'b00}, xw, xbe, 0};
         q.push_back(e);
         e = '{K_DONE, 0, 0, 0, c + 1 + extra + lat};
         q.push_back(e);
      end
      @(posedge clk); #1;
      req_addr = 32'hFFFF_FFFF;
      req_data = 32'h0;
      req_size = SIZE_BYTE;
      if (mis) begin
         req_valid = 1'b0;
         chk("ready_after_mis", req_ready, 1);
         chk("we_mis", mem_we, 0);
         @(posedge clk); #1;
         chk("we_mis2", mem_we, 0);
         return;
      end
      if (extra != 0) begin
         chk("re_read", mem_re, 1);
         chk("we_read", mem_we, 0);
         chk("addr_read", mem_addr, {a[31:2], 2'b00});
         mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      for (int k = 0; k < lat; k++) begin
         chk("we_hold", mem_we, 1);
         chk("re_low_w", mem_re, 0);
         chk("ready_busy", req_ready, 0);
         chk("addr_hold", mem_addr, {a[31:2], 2'b00});
         chk("wdata_hold", mem_wdata, xw);
         chk("be_hold", {28'd0, mem_be}, {28'd0, xbe});
         mem_ack = (k == lat - 1);
         @(posedge clk); #1;
      end
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      chk("ready_fin", req_ready, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_ready", req_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
      chk("rst_be", {28'd0, mem_be}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      store(32'h0000_1003, SIZE_BYTE, 32'h1234_56AB, 1,
            32'hABAB_ABAB, 4'b1000, 1'b0);
      store(32'h0000_2002, SIZE_HALF, 32'hFFFF_BEEF, 3,
            32'hBEEF_BEEF, 4'b1100, 1'b0);
      store(32'h0000_3001, SIZE_WORD, 32'h0, 0, 32'h0, 4'b0, 1'b1);
      store(32'h0000_5000, SIZE_WORD, 32'hDEAD_BEEF, 2,
            32'hDEAD_BEEF, 4'b1111, 1'b0);
      store(32'h0000_6000, SIZE_BYTE, 32'h0000_007F, 1,
            32'h7F7F_7F7F, 4'b0001, 1'b0);
      store(32'h0000_7000, SIZE_HALF, 32'h0000_A5C3, 1,
            32'hA5C3_A5C3, 4'b0011, 1'b0);
      store(32'h0000_1001, SIZE_HALF, 32'h0, 0, 32'h0, 4'b0, 1'b1);
      store(32'h0000_9000, SIZE_RSVD, 32'h0, 0, 32'h0, 4'b0, 1'b1);
      store(32'h0000_4001, SIZE_BYTE, 32'h0000_0055, 1,
            32'h5555_5555, 4'b0010, 1'b0);
      store(32'h0000_4002, SIZE_BYTE, 32'h0000_0012, 2,
            32'h1212_1212, 4'b0100, 1'b0);

      mem_ack = 1'b1;
      @(posedge clk); #1;
      chk("idle_ack_ready", req_ready, 1);
      chk("idle_ack_we", mem_we, 0);
      mem_ack = 1'b0;

      req_valid = 1'b1;
      req_addr  = 32'h0000_8000;
      req_size  = SIZE_WORD;
      req_data  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pre_rst_we", mem_we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_we", mem_we, 0);
      chk("async_ready", req_ready, 1);
      chk("async_done", done, 0);
      chk("async_addr", mem_addr, 0);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_we", mem_we, 0);
      mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
